obi_arbiter_2to1: RTL and testbench

OBI_ARBITER_2TO1 -- requirements
Module: obi_arbiter_2to1

---
 rtl/obi_pkg.sv | 6 +
 rtl/obi_rr_pick.sv | 10 +
 rtl/obi_arbiter_2to1.sv | 128 ++++++++++++
 tb/tb_obi_arbiter_2to1.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/obi_pkg.sv
// obi_pkg: shared FSM encoding and defaults for the OBI 2:1 arbiter
// Contents: obi_arb_state_t (IDLE/ADDR/RESP/TOUT), OBI_TIMEOUT_DEFAULT response-wait limit
package obi_pkg;
    typedef enum logic [1:0] {IDLE, ADDR, RESP, TOUT} obi_arb_state_t;
    localparam int unsigned OBI_TIMEOUT_DEFAULT = 16;
endpackage

// File: rtl/obi_rr_pick.sv
// obi_rr_pick: combinational two-way winner select with a priority pointer
// Ports: i_req0/i_req1 requests, i_prio manager favoured on contention, o_win winning manager index
module obi_rr_pick (
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_prio,
    output logic o_win
);
    assign o_win = (i_req0 && i_req1) ? i_prio : i_req1;
endmodule

// File: rtl/obi_arbiter_2to1.sv
// obi_arbiter_2to1: shares one OBI subordinate between two managers, one transaction outstanding
// Ports: clk_i/reset_ni clock and async active-low reset; m0_*/m1_* manager address and response
// channels; s_* subordinate channel. Response wait limited by TIMEOUT_CYCLES, then an error response.
module obi_arbiter_2to1 import obi_pkg::*; #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = OBI_TIMEOUT_DEFAULT
) (
    input  logic                    clk_i,
    input  logic                    reset_ni,
    input  logic                    m0_req_i,
    output logic                    m0_gnt_o,
    input  logic [ADDR_WIDTH-1:0]   m0_addr_i,
    input  logic                    m0_we_i,
    input  logic [DATA_WIDTH/8-1:0] m0_be_i,
    input  logic [DATA_WIDTH-1:0]   m0_wdata_i,
    output logic                    m0_rvalid_o,
    input  logic                    m0_rready_i,
    output logic [DATA_WIDTH-1:0]   m0_rdata_o,
    output logic                    m0_err_o,
    input  logic                    m1_req_i,
    output logic                    m1_gnt_o,
    input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
    input  logic                    m1_we_i,
    input  logic [DATA_WIDTH/8-1:0] m1_be_i,
    input  logic [DATA_WIDTH-1:0]   m1_wdata_i,
    output logic                    m1_rvalid_o,
    input  logic                    m1_rready_i,
    output logic [DATA_WIDTH-1:0]   m1_rdata_o,
    output logic                    m1_err_o,
    output logic                    s_req_o,
    input  logic                    s_gnt_i,
    output logic [ADDR_WIDTH-1:0]   s_addr_o,
    output logic                    s_we_o,
    output logic [DATA_WIDTH/8-1:0] s_be_o,
    output logic [DATA_WIDTH-1:0]   s_wdata_o,
    input  logic                    s_rvalid_i,
    output logic                    s_rready_o,
    input  logic [DATA_WIDTH-1:0]   s_rdata_i,
    input  logic                    s_err_i
);
    localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYCLES);

    obi_arb_state_t r_state, w_state_nx;
    logic           r_owner, w_owner_nx;
    logic           r_prio, w_prio_nx;
    logic [7:0]     r_wait, w_wait_nx;
    logic           w_win, w_own_rready, w_sel, w_areq, w_resp, w_tout, w_rv, w_er;
    logic [DATA_WIDTH-1:0] w_rd;

    obi_rr_pick u_pick (
        .i_req0 (m0_req_i),
        .i_req1 (m1_req_i),
        .i_prio (r_prio),
        .o_win  (w_win)
    );

    assign w_own_rready = r_owner ? m1_rready_i : m0_rready_i;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state <= IDLE;
            r_owner <= 1'b0;
            r_prio  <= 1'b0;
            r_wait  <= '0;
        end else begin
            r_state <= w_state_nx;
            r_owner <= w_owner_nx;
            r_prio  <= w_prio_nx;
            r_wait  <= w_wait_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_owner_nx = r_owner;
        w_prio_nx  = r_prio;
        w_wait_nx  = r_wait;
        case (r_state)
            IDLE: if (m0_req_i || m1_req_i) begin
                w_owner_nx = w_win;
                w_state_nx = s_gnt_i ? RESP : ADDR;
                w_wait_nx  = '0;
            end
            ADDR: if (s_gnt_i) begin
                w_state_nx = RESP;
                w_wait_nx  = '0;
            end
            RESP: if (s_rvalid_i) begin
                w_state_nx = w_own_rready ? IDLE : RESP;
                w_prio_nx  = w_own_rready ? !r_owner : r_prio;
            end else begin
                // Only cycles with no response at all count toward the timeout
                w_wait_nx  = r_wait + 8'd1;
                w_state_nx = (w_wait_nx == TO_LIMIT) ? TOUT : RESP;
            end
            TOUT: if (w_own_rready) begin
                w_state_nx = IDLE;
                w_prio_nx  = !r_owner;
            end
        endcase
    end

    always_comb begin
        // In IDLE the arbitration winner drives the bus before it is latched as owner
        w_sel       = (r_state == IDLE) ? w_win : r_owner;
        w_areq      = (r_state == ADDR) || (r_state == IDLE && (m0_req_i || m1_req_i));
        s_req_o     = w_areq;
        s_addr_o    = w_areq ? (w_sel ? m1_addr_i : m0_addr_i) : '0;
        s_we_o      = w_areq && (w_sel ? m1_we_i : m0_we_i);
        s_be_o      = w_areq ? (w_sel ? m1_be_i : m0_be_i) : '0;
        s_wdata_o   = w_areq ? (w_sel ? m1_wdata_i : m0_wdata_i) : '0;
        m0_gnt_o    = w_areq && !w_sel && s_gnt_i;
        m1_gnt_o    = w_areq && w_sel && s_gnt_i;
        w_resp      = (r_state == RESP);
        w_tout      = (r_state == TOUT);
        w_rv        = w_tout || (w_resp && s_rvalid_i);
        w_er        = w_tout || (w_resp && s_err_i);
        w_rd        = w_resp ? s_rdata_i : '0;
        m0_rvalid_o = w_rv && !r_owner;
        m0_err_o    = w_er && !r_owner;
        m0_rdata_o  = r_owner ? '0 : w_rd;
        m1_rvalid_o = w_rv && r_owner;
        m1_err_o    = w_er && r_owner;
        m1_rdata_o  = r_owner ? w_rd : '0;
        s_rready_o  = w_tout || (w_resp && w_own_rready);
    end
endmodule

// File: tb/tb_obi_arbiter_2to1.sv
// tb_obi_arbiter_2to1: directed and randomized checks of the 2:1 OBI arbiter against a transaction model
module tb_obi_arbiter_2to1;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic reset_ni = 1'b0;
    logic m0_req_i, m0_we_i, m0_rready_i, m1_req_i, m1_we_i, m1_rready_i;
    logic [AW-1:0] m0_addr_i, m1_addr_i;
    logic [BW-1:0] m0_be_i, m1_be_i;
    logic [DW-1:0] m0_wdata_i, m1_wdata_i;
    logic m0_gnt_o, m0_rvalid_o, m0_err_o, m1_gnt_o, m1_rvalid_o, m1_err_o;
    logic [DW-1:0] m0_rdata_o, m1_rdata_o;
    logic s_req_o, s_gnt_i, s_we_o, s_rvalid_i, s_rready_o, s_err_i;
    logic [AW-1:0] s_addr_o;
    logic [BW-1:0] s_be_o;
    logic [DW-1:0] s_wdata_o, s_rdata_i;

    int n_chk = 0;
    int n_err = 0;
    bit m_busy, m_granted, m_to, m_owner, m_pri;
    int m_waited;

    always #5 clk = ~clk;

    obi_arbiter_2to1 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk), .reset_ni(reset_ni),
        .m0_req_i(m0_req_i), .m0_gnt_o(m0_gnt_o), .m0_addr_i(m0_addr_i), .m0_we_i(m0_we_i),
        .m0_be_i(m0_be_i), .m0_wdata_i(m0_wdata_i), .m0_rvalid_o(m0_rvalid_o),
        .m0_rready_i(m0_rready_i), .m0_rdata_o(m0_rdata_o), .m0_err_o(m0_err_o),
        .m1_req_i(m1_req_i), .m1_gnt_o(m1_gnt_o), .m1_addr_i(m1_addr_i), .m1_we_i(m1_we_i),
        .m1_be_i(m1_be_i), .m1_wdata_i(m1_wdata_i), .m1_rvalid_o(m1_rvalid_o),
        .m1_rready_i(m1_rready_i), .m1_rdata_o(m1_rdata_o), .m1_err_o(m1_err_o),
        .s_req_o(s_req_o), .s_gnt_i(s_gnt_i), .s_addr_o(s_addr_o), .s_we_o(s_we_o),
        .s_be_o(s_be_o), .s_wdata_o(s_wdata_o), .s_rvalid_i(s_rvalid_i),
        .s_rready_o(s_rready_o), .s_rdata_i(s_rdata_i), .s_err_i(s_err_i)
    );

    task automatic chk(string tag, logic [127:0] got, logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic clr();
        {m0_req_i, m0_we_i, m0_rready_i, m1_req_i, m1_we_i, m1_rready_i} = '0;
        {m0_addr_i, m1_addr_i, m0_wdata_i, m1_wdata_i} = '0;
        m0_be_i = '1;
        m1_be_i = '1;
        {s_gnt_i, s_rvalid_i, s_err_i, s_rdata_i} = '0;
    endtask

    function automatic void model_reset();
        m_busy = 0; m_granted = 0; m_to = 0; m_owner = 0; m_pri = 0; m_waited = 0;
    endfunction

    // Check every output against the transaction model, then advance the model over the coming edge
    task automatic eval();
        logic [1:0]  g;
        logic [69:0] a;
        logic [33:0] r0, r1, rr;
        logic        srr, own_rr, w, addr_phase;
        @(negedge clk);
        w = m_busy ? m_owner : ((m0_req_i && m1_req_i) ? m_pri : m1_req_i);
        addr_phase = m_busy ? !m_granted : (m0_req_i || m1_req_i);
        own_rr = m_owner ? m1_rready_i : m0_rready_i;
        a = addr_phase ? {1'b1, w ? m1_addr_i : m0_addr_i, w ? m1_we_i : m0_we_i,
                          w ? m1_be_i : m0_be_i, w ? m1_wdata_i : m0_wdata_i} : '0;
        g = (addr_phase && s_gnt_i) ? (w ? 2'b01 : 2'b10) : 2'b00;
        rr = '0;
        srr = 0;
        if (m_busy && m_granted) begin
            rr = m_to ? {2'b11, 32'h0} : {s_rvalid_i, s_err_i, s_rdata_i};
            srr = m_to ? 1'b1 : own_rr;
        end
        r0 = m_owner ? '0 : rr;
        r1 = m_owner ? rr : '0;
        chk("gnt", {m0_gnt_o, m1_gnt_o}, g);
        chk("addr_phase", {s_req_o, s_addr_o, s_we_o, s_be_o, s_wdata_o}, a);
        chk("m0_resp", {m0_rvalid_o, m0_err_o, m0_rdata_o}, r0);
        chk("m1_resp", {m1_rvalid_o, m1_err_o, m1_rdata_o}, r1);
        chk("s_rready", s_rready_o, srr);
        if (!m_busy) begin
            if (m0_req_i || m1_req_i) begin
                m_busy = 1; m_owner = w; m_granted = s_gnt_i; m_waited = 0;
            end
        end else if (!m_granted) begin
            if (s_gnt_i) begin m_granted = 1; m_waited = 0; end
        end else if (m_to || s_rvalid_i) begin
            if (own_rr) begin m_busy = 0; m_to = 0; m_pri = !m_owner; end
        end else begin
            m_waited++;
            if (m_waited == TO) m_to = 1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc();
        eval();
        tick();
    endtask

    task automatic pulse_reset();
        reset_ni = 1'b0;
        #2;
        reset_ni = 1'b1;
        model_reset();
    endtask

    initial begin
        bit dead;
        clr();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        eval();
        chk("rst_outputs", {s_req_o, m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o, s_rready_o}, 6'b0);
        tick();
        reset_ni = 1'b1;
        // Single read by m0 with same-cycle grant
        m0_req_i = 1; m0_addr_i = 32'h10; s_gnt_i = 1;
        eval();
        chk("t27_gnt", {m0_gnt_o, m1_gnt_o}, 2'b10);
        chk("t27_addr", s_addr_o, 32'h10);
        tick();
        m0_req_i = 0; s_gnt_i = 0; m0_rready_i = 1;
        cyc();
        s_rvalid_i = 1; s_rdata_i = 32'hDEADBEEF;
        eval();
        chk("t27_rdata", {m0_rvalid_o, m0_rdata_o}, {1'b1, 32'hDEADBEEF});
        chk("t27_m1_quiet", {m1_rvalid_o, m1_err_o, m1_rdata_o, m1_gnt_o}, 35'h0);
        tick();
        clr();
        pulse_reset();
        // Simultaneous requests alternate starting with m0
        m0_req_i = 1; m1_req_i = 1; m0_addr_i = 32'h100; m1_addr_i = 32'h200; s_gnt_i = 1;
        eval();
        chk("t28_first", {m0_gnt_o, m1_gnt_o}, 2'b10);
        tick();
        s_gnt_i = 0; s_rvalid_i = 1; m0_rready_i = 1; m1_rready_i = 1;
        cyc();
        s_gnt_i = 1; s_rvalid_i = 0;
        eval();
        chk("t28_second", {m0_gnt_o, m1_gnt_o}, 2'b01);
        tick();
        s_gnt_i = 0; s_rvalid_i = 1;
        cyc();
        clr();
        // Address held on m1 while the subordinate stalls
        m1_req_i = 1; m1_addr_i = 32'h300;
        eval();
        chk("t29_addr0", s_addr_o, 32'h300);
        tick();
        m0_req_i = 1; m0_addr_i = 32'h400;
        for (int i = 0; i < 2; i++) begin
            eval();
            chk("t29_addr", s_addr_o, 32'h300);
            chk("t29_m0_gnt", m0_gnt_o, 1'b0);
            tick();
        end
        s_gnt_i = 1;
        eval();
        chk("t29_grant", {m0_gnt_o, m1_gnt_o}, 2'b01);
        tick();
        s_gnt_i = 0; s_rvalid_i = 1; m1_rready_i = 1; m1_req_i = 0;
        cyc();
        s_rvalid_i = 0; s_gnt_i = 1;
        eval();
        chk("t21_waiter_served", {m0_gnt_o, s_addr_o}, {1'b1, 32'h400});
        tick();
        m0_req_i = 0; s_gnt_i = 0; s_rvalid_i = 1; m0_rready_i = 1;
        cyc();
        clr();
        // Subordinate never responds: error response after TO response cycles
        m0_req_i = 1; s_gnt_i = 1;
        cyc();
        m0_req_i = 0; s_gnt_i = 0; s_rdata_i = 32'h12345678;
        for (int i = 0; i < TO; i++) begin
            eval();
            chk("t30_waiting", m0_rvalid_o, 1'b0);
            tick();
        end
        eval();
        chk("t30_tout", {m0_rvalid_o, m0_err_o, m0_rdata_o, s_rready_o, s_req_o}, {2'b11, 32'h0, 2'b10});
        tick();
        cyc();
        m0_rready_i = 1;
        cyc();
        m0_rready_i = 0;
        eval();
        chk("t30_idle", {s_req_o, m0_rvalid_o, s_rready_o}, 3'b0);
        tick();
        // Owner back-pressures a valid response
        m1_req_i = 1; s_gnt_i = 1;
        cyc();
        m1_req_i = 0; s_gnt_i = 0; s_rvalid_i = 1; s_rdata_i = 32'hCAFEF00D;
        for (int i = 0; i < 2; i++) begin
            eval();
            chk("t31_srready", s_rready_o, 1'b0);
            chk("t31_data", {m1_rvalid_o, m1_rdata_o}, {1'b1, 32'hCAFEF00D});
            tick();
        end
        m1_rready_i = 1;
        cyc();
        clr();
        // Asynchronous reset in the middle of a response
        m1_req_i = 1; s_gnt_i = 1;
        cyc();
        m1_req_i = 0; s_gnt_i = 0; s_rvalid_i = 1;
        eval();
        #1 reset_ni = 1'b0;
        #1;
        chk("t32_async", {m0_rvalid_o, m1_rvalid_o, m0_gnt_o, m1_gnt_o, s_rready_o}, 5'b0);
        model_reset();
        #1 reset_ni = 1'b1;
        tick();
        m0_req_i = 1; m1_req_i = 1; s_gnt_i = 1; s_rvalid_i = 0;
        eval();
        chk("t32_prio", {m0_gnt_o, m1_gnt_o}, 2'b10);
        tick();
        clr();
        // Randomized traffic, with stretches of a subordinate that never responds
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) dead = ($urandom_range(0, 2) == 0);
            m0_req_i = ($urandom_range(0, 2) != 0);
            m1_req_i = ($urandom_range(0, 2) != 0);
            m0_addr_i = $urandom; m1_addr_i = $urandom;
            m0_wdata_i = $urandom; m1_wdata_i = $urandom;
            m0_we_i = 1'($urandom); m1_we_i = 1'($urandom);
            m0_be_i = 4'($urandom); m1_be_i = 4'($urandom);
            m0_rready_i = ($urandom_range(0, 3) != 0);
            m1_rready_i = ($urandom_range(0, 3) != 0);
            s_gnt_i = ($urandom_range(0, 2) == 0);
            s_rvalid_i = !dead && ($urandom_range(0, 3) == 0);
            s_err_i = 1'($urandom);
            s_rdata_i = $urandom;
            cyc();
        end
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
